// File: rtl/uart_line_echo_ctrl.sv
// Line-buffered echo controller on the UART FIFO side: collects RX bytes into a line,
// replays the line into TX followed by CR LF. Optional macro UART_ECHO_UPCASE_EN upper-cases a-z on store.
module uart_line_echo_ctrl #(
  parameter int unsigned LINE_DEPTH = 16,
  parameter logic [7:0]  TERM       = 8'h0D,
  parameter logic [7:0]  LF_CHAR    = 8'h0A
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] r_data,
  input  logic       rx_empty,
  input  logic       tx_full,
  output logic       rd,
  output logic       wr,
  output logic [7:0] w_data,
  output logic       busy,
  output logic [7:0] line_count
);

  localparam int unsigned CNT_W = $clog2(LINE_DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(LINE_DEPTH);
  localparam logic [CNT_W-1:0] FULL_LEN = CNT_W'(LINE_DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SEND    = 2'd1,
    SEND_CR = 2'd2,
    SEND_LF = 2'd3
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] len_r;
  logic [CNT_W-1:0] rd_idx_r;
  logic [7:0]       line_count_r;
  logic [7:0]       line_buf_r [LINE_DEPTH];

  logic       rd_s;
  logic       wr_s;
  logic       store_s;
  logic       is_term_s;
  logic       is_full_s;
  logic       last_s;
  logic [7:0] w_data_s;

  function automatic logic [7:0] store_byte(input logic [7:0] b);
`ifdef UART_ECHO_UPCASE_EN
    if (b >= 8'h61 && b <= 8'h7A) begin
      return b - 8'h20;
    end else begin
      return b;
    end
`else
    return b;
`endif
  endfunction

  // Strobe and data decode from registered state and FIFO flags
  always_comb begin
    is_full_s = (len_r == FULL_LEN);
    is_term_s = (r_data == TERM);
    last_s    = ((rd_idx_r + ONE_CNT) == len_r);
    rd_s      = 1'b0;
    wr_s      = 1'b0;
    store_s   = 1'b0;
    w_data_s  = 8'h00;
    case (state_r)
      COLLECT: begin
        // A full buffer leaves the next byte (even a terminator) in the RX FIFO
        if (!is_full_s && !rx_empty) begin
          rd_s    = 1'b1;
          store_s = !is_term_s;
        end else begin
          rd_s = 1'b0;
        end
      end
      SEND: begin
        w_data_s = line_buf_r[rd_idx_r[IDX_W-1:0]];
        wr_s     = !tx_full;
      end
      SEND_CR: begin
        w_data_s = 8'h0D;
        wr_s     = !tx_full;
      end
      SEND_LF: begin
        w_data_s = LF_CHAR;
        wr_s     = !tx_full;
      end
      default: begin
        w_data_s = 8'h00;
      end
    endcase
  end

  assign rd         = rd_s & reset_n;
  assign wr         = wr_s & reset_n;
  assign w_data     = reset_n ? w_data_s : 8'h00;
  assign busy       = (state_r != COLLECT);
  assign line_count = line_count_r;

  // Control FSM with line length, replay index and completed-line counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= COLLECT;
      len_r        <= ZERO_CNT;
      rd_idx_r     <= ZERO_CNT;
      line_count_r <= 8'h00;
    end else begin
      case (state_r)
        COLLECT: begin
          if (is_full_s) begin
            state_r <= SEND;
          end else if (rd_s && is_term_s) begin
            state_r <= (len_r == ZERO_CNT) ? SEND_CR : SEND;
          end else if (rd_s) begin
            len_r <= len_r + ONE_CNT;
          end
        end
        SEND: begin
          if (wr_s) begin
            rd_idx_r <= rd_idx_r + ONE_CNT;
            if (last_s) begin
              state_r <= SEND_CR;
            end
          end
        end
        SEND_CR: begin
          if (wr_s) begin
            state_r <= SEND_LF;
          end
        end
        SEND_LF: begin
          if (wr_s) begin
            state_r      <= COLLECT;
            len_r        <= ZERO_CNT;
            rd_idx_r     <= ZERO_CNT;
            line_count_r <= line_count_r + 8'd1;
          end
        end
        default: begin
          state_r <= COLLECT;
        end
      endcase
    end
  end

  // Line storage; contents are irrelevant after reset so no reset is applied
  always_ff @(posedge clk) begin
    if (store_s) begin
      line_buf_r[len_r[IDX_W-1:0]] <= store_byte(r_data);
    end
  end

endmodule

// File: tb/tb_uart_line_echo_ctrl.sv
// Directed self-checking bench for uart_line_echo_ctrl with an RX FIFO model and TX capture log.
module tb_uart_line_echo_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] r_data = 8'h00;
  logic       rx_empty = 1'b1;
  logic       tx_full = 1'b0;
  logic       rd, wr, busy;
  logic [7:0] w_data, line_count;

  int errors = 0;
  int checks = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  int         tx_cyc[$];
  int         cyc = 0;
  int         last_pop_cyc = 0;
  int         rd_viol = 0;
  int         wr_viol = 0;
  bit         stall_arm = 1'b0;
  int         stall_left = 0;
  logic       m_rd, m_wr, m_re, m_tf;
  logic [7:0] m_wd;

  uart_line_echo_ctrl dut (
    .clk(clk), .reset_n(reset_n), .r_data(r_data), .rx_empty(rx_empty), .tx_full(tx_full),
    .rd(rd), .wr(wr), .w_data(w_data), .busy(busy), .line_count(line_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] up(input logic [7:0] b);
`ifdef UART_ECHO_UPCASE_EN
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
    return b;
  endfunction

  task automatic refresh_rx();
    rx_empty = (rx_q.size() == 0);
    r_data   = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_q.push_back(b);
    refresh_rx();
  endtask

  // FIFO model: sample strobes at the edge, apply pops/pushes just after it
  always @(posedge clk) begin
    m_rd = rd; m_wr = wr; m_wd = w_data; m_re = rx_empty; m_tf = tx_full;
    #1;
    cyc++;
    if (m_rd && m_re) rd_viol++;
    if (m_wr && m_tf) wr_viol++;
    if (m_rd && rx_q.size() != 0) begin
      void'(rx_q.pop_front());
      last_pop_cyc = cyc;
    end
    if (m_wr) begin
      tx_q.push_back(m_wd);
      tx_cyc.push_back(cyc);
    end
    if (stall_left > 0) begin
      stall_left--;
      if (stall_left == 0) tx_full = 1'b0;
    end else if (stall_arm && m_wr) begin
      stall_arm  = 1'b0;
      tx_full    = 1'b1;
      stall_left = 10;
    end
    refresh_rx();
  end

  task automatic wait_line(input logic [7:0] target, input int left, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (line_count == target && !busy && rx_q.size() == left) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    push_rx(8'h55);
    #1;
    checks++; if (rd !== 1'b0) begin errors++; $display("FAIL reset_rd got=%b exp=0", rd); end
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL reset_wr got=%b exp=0", wr); end
    checks++; if (w_data !== 8'h00) begin errors++; $display("FAIL reset_wdata got=%h exp=00", w_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (line_count !== 8'h00) begin errors++; $display("FAIL reset_count got=%h exp=00", line_count); end
    rx_q.delete();
    refresh_rx();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || rd !== 1'b0) begin errors++; $display("FAIL post_reset busy=%b rd=%b exp 0 0", busy, rd); end
  endtask

  task automatic test_basic();
    logic [7:0] e[$];
    bit ok;
    e = {up(8'h61), up(8'h62), up(8'h63), 8'h0D, 8'h0A};
    tx_q.delete(); tx_cyc.delete();
    push_rx(8'h61); push_rx(8'h62); push_rx(8'h63); push_rx(8'h0D);
    wait_line(8'd1, 0, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout count=%h exp=01", line_count); end
    checks++; if (tx_q.size() != e.size()) begin errors++; $display("FAIL basic_len got=%0d exp=%0d", tx_q.size(), e.size()); end
    for (int i = 0; i < e.size() && i < tx_q.size(); i++) begin
      checks++;
      if (tx_q[i] !== e[i]) begin errors++; $display("FAIL basic_byte[%0d] got=%h exp=%h", i, tx_q[i], e[i]); end
      checks++;
      if (tx_cyc[i] != tx_cyc[0] + i) begin errors++; $display("FAIL basic_cycle[%0d] got=%0d exp=%0d", i, tx_cyc[i], tx_cyc[0] + i); end
    end
    if (tx_cyc.size() != 0) begin
      checks++;
      if (tx_cyc[0] != last_pop_cyc + 1) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", tx_cyc[0], last_pop_cyc + 1); end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    tx_q.delete(); tx_cyc.delete();
    for (int b = 8'h30; b <= 8'h40; b++) push_rx(8'(b));
    wait_line(8'd2, 1, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout count=%h qsize=%0d exp 02 1", line_count, rx_q.size()); end
    checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h40) begin errors++; $display("FAIL ovf_rx_head size=%0d exp 1 with head 40", rx_q.size()); end
    checks++; if (tx_q.size() != 18) begin errors++; $display("FAIL ovf_len got=%0d exp=18", tx_q.size()); end
    for (int i = 0; i < 16 && i < tx_q.size(); i++) begin
      checks++;
      if (tx_q[i] !== 8'(8'h30 + i)) begin errors++; $display("FAIL ovf_byte[%0d] got=%h exp=%h", i, tx_q[i], 8'(8'h30 + i)); end
    end
    if (tx_q.size() == 18) begin
      checks++;
      if (tx_q[16] !== 8'h0D || tx_q[17] !== 8'h0A) begin errors++; $display("FAIL ovf_crlf got=%h %h exp=0d 0a", tx_q[16], tx_q[17]); end
    end
    tx_q.delete(); tx_cyc.delete();
    push_rx(8'h0D);
    wait_line(8'd3, 0, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_next_timeout count=%h exp=03", line_count); end
    checks++; if (tx_q.size() != 3 || tx_q[0] !== 8'h40 || tx_q[1] !== 8'h0D || tx_q[2] !== 8'h0A) begin
      errors++; $display("FAIL ovf_next_line size=%0d exp 3 bytes 40 0d 0a", tx_q.size());
    end
  endtask

  task automatic test_empty_line();
    bit ok;
    tx_q.delete(); tx_cyc.delete();
    push_rx(8'h0D);
    wait_line(8'd4, 0, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL empty_timeout count=%h exp=04", line_count); end
    checks++; if (tx_q.size() != 2 || tx_q[0] !== 8'h0D || tx_q[1] !== 8'h0A) begin
      errors++; $display("FAIL empty_bytes size=%0d exp 2 bytes 0d 0a", tx_q.size());
    end
  endtask

  task automatic test_stall();
    logic [7:0] e[$];
    int seen = 0;
    int bad = 0;
    bit done = 1'b0;
    e = {up(8'h78), up(8'h79), 8'h0D, 8'h0A};
    tx_q.delete(); tx_cyc.delete();
    stall_arm = 1'b1;
    push_rx(8'h78); push_rx(8'h79); push_rx(8'h0D);
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (tx_full) begin
        seen++;
        if (wr !== 1'b0 || w_data !== up(8'h79)) bad++;
      end
      if (line_count == 8'd5 && !busy) done = 1'b1;
    end
    checks++; if (!done) begin errors++; $display("FAIL stall_timeout count=%h exp=05", line_count); end
    checks++; if (seen != 10) begin errors++; $display("FAIL stall_cycles got=%0d exp=10", seen); end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold bad_cycles=%0d exp=0", bad); end
    checks++; if (tx_q.size() != e.size()) begin errors++; $display("FAIL stall_len got=%0d exp=%0d", tx_q.size(), e.size()); end
    for (int i = 0; i < e.size() && i < tx_q.size(); i++) begin
      checks++;
      if (tx_q[i] !== e[i]) begin errors++; $display("FAIL stall_byte[%0d] got=%h exp=%h", i, tx_q[i], e[i]); end
    end
  endtask

  task automatic test_reset_mid_send();
    bit ok = 1'b0;
    tx_q.delete(); tx_cyc.delete();
    push_rx(8'h61); push_rx(8'h62); push_rx(8'h63); push_rx(8'h0D);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (tx_q.size() == 2) ok = 1'b1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL midrst_timeout pushed=%0d exp=2", tx_q.size()); end
    reset_n = 1'b0;
    push_rx(8'h31);
    #1;
    checks++; if (rd !== 1'b0 || wr !== 1'b0) begin errors++; $display("FAIL midrst_strobes rd=%b wr=%b exp 0 0", rd, wr); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (line_count !== 8'h00) begin errors++; $display("FAIL midrst_count got=%h exp=00", line_count); end
    tx_q.delete(); tx_cyc.delete();
    push_rx(8'h0D);
    wait_line(8'd1, 0, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_next_timeout count=%h exp=01", line_count); end
    checks++; if (tx_q.size() != 3 || tx_q[0] !== 8'h31 || tx_q[1] !== 8'h0D || tx_q[2] !== 8'h0A) begin
      errors++; $display("FAIL midrst_next_line size=%0d exp 3 bytes 31 0d 0a", tx_q.size());
    end
  endtask

  task automatic test_wrap();
    bit ok;
    tx_q.delete(); tx_cyc.delete();
    for (int i = 0; i < 254; i++) push_rx(8'h0D);
    wait_line(8'd255, 0, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_255 count=%h exp=ff", line_count); end
    push_rx(8'h0D);
    wait_line(8'd0, 0, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_zero count=%h exp=00", line_count); end
    checks++; if (tx_q.size() != 510) begin errors++; $display("FAIL wrap_bytes got=%0d exp=510", tx_q.size()); end
    checks++; if (rd_viol != 0) begin errors++; $display("FAIL rd_when_empty got=%0d exp=0", rd_viol); end
    checks++; if (wr_viol != 0) begin errors++; $display("FAIL wr_when_full got=%0d exp=0", wr_viol); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_empty_line();
    test_stall();
    test_reset_mid_send();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
